// File: rtl/cache_mem_responder.sv
// Memory-side responder for the data-cache interface.
// Word-addressed backing store with a fixed, programmable access latency.
module cache_mem_responder #(
    parameter int WORD_W    = 32,
    parameter int ADDR_BITS = 10,
    parameter int LAT       = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic [15:0]       xfer_count
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CW    = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t state, state_nxt;

    logic [WORD_W-1:0]    mem [DEPTH];
    logic [ADDR_BITS-1:0] idx, idx_in, idx_nxt;
    logic                 wr, wr_nxt;
    logic [WORD_W-1:0]    wdata, wdata_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 req;
    logic                 match;
    logic                 unused_addr;

    assign req    = dREN | dWEN;
    assign idx_in = daddr[ADDR_BITS+1:2];
    assign match  = req && (idx_in == idx) && (dWEN == wr);

    // Upper address bits alias and byte-offset bits carry no meaning.
    assign unused_addr = ^{daddr[WORD_W-1:ADDR_BITS+2], daddr[1:0]};

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_nxt    = wr;
        wdata_nxt = wdata;
        cnt_nxt   = cnt;
        dwait     = 1'b1;
        unique case (state)
            IDLE: begin
                if (req) begin
                    idx_nxt   = idx_in;
                    wr_nxt    = dWEN;
                    wdata_nxt = dstore;
                    cnt_nxt   = CW'(LAT);
                    state_nxt = (LAT > 0) ? BUSY : ACK;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 1'b1;
                if (!match) begin
                    state_nxt = IDLE;
                end else if (cnt == CW'(1)) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                dwait     = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            idx        <= '0;
            wr         <= 1'b0;
            wdata      <= '0;
            cnt        <= '0;
            dload      <= '0;
            xfer_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[ADDR_BITS'(i)] <= '0;
            end
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            wr    <= wr_nxt;
            wdata <= wdata_nxt;
            cnt   <= cnt_nxt;
            // Read data is captured on the edge that enters ACK.
            if (state_nxt == ACK && !wr_nxt) begin
                dload <= mem[idx_nxt];
            end
            if (state == ACK) begin
                xfer_count <= xfer_count + 16'd1;
                if (wr) begin
                    mem[idx] <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized self-checking bench for cache_mem_responder.
// Two instances: LAT=2 (index 0) and LAT=0 (index 1).
module tb_cache_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        dren   [2];
    logic        dwen   [2];
    logic [31:0] daddr  [2];
    logic [31:0] dstore [2];
    logic [31:0] dload  [2];
    logic        dwait  [2];
    logic [15:0] xfer   [2];

    logic [31:0] mem_m   [2][1024];
    logic [31:0] dload_m [2];
    logic [15:0] cnt_m   [2];

    int n_chk;
    int n_fail;
    int cyc;

    cache_mem_responder #(.WORD_W(32), .ADDR_BITS(10), .LAT(2)) u0 (
        .CLK(clk), .nRST(rst_n),
        .dREN(dren[0]), .dWEN(dwen[0]),
        .daddr(daddr[0]), .dstore(dstore[0]),
        .dload(dload[0]), .dwait(dwait[0]),
        .xfer_count(xfer[0])
    );

    cache_mem_responder #(.WORD_W(32), .ADDR_BITS(10), .LAT(0)) u1 (
        .CLK(clk), .nRST(rst_n),
        .dREN(dren[1]), .dWEN(dwen[1]),
        .daddr(daddr[1]), .dstore(dstore[1]),
        .dload(dload[1]), .dwait(dwait[1]),
        .xfer_count(xfer[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 1024; j++) mem_m[i][j] = '0;
            dload_m[i] = '0;
            cnt_m[i]   = '0;
        end
    endtask

    // One complete transaction from IDLE, checked against the model.
    task automatic do_xfer(input int i, input bit wr, input bit both,
                           input logic [31:0] addr, input logic [31:0] data,
                           input string nm);
        int k;
        logic [9:0] ix;
        ix        = addr[11:2];
        dren[i]   = !wr || both;
        dwen[i]   = wr;
        daddr[i]  = addr;
        dstore[i] = data;
        k = 0;
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (wr) dstore[i] = $urandom;
            if (dwait[i] === 1'b0) break;
        end
        if (wr) mem_m[i][ix] = data;
        else    dload_m[i]   = mem_m[i][ix];
        n_chk++;
        if (k != lat(i) + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, want %0d", nm, k, lat(i) + 1);
        end
        n_chk++;
        if (dload[i] !== dload_m[i]) begin
            n_fail++;
            $display("FAIL %s dload: got %h, want %h", nm, dload[i], dload_m[i]);
        end
        @(posedge clk); #1;
        dren[i] = 1'b0;
        dwen[i] = 1'b0;
        cnt_m[i]++;
        n_chk++;
        if (xfer[i] !== cnt_m[i] || dwait[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s count/idle: got cnt=%h dwait=%b, want cnt=%h dwait=1",
                     nm, xfer[i], dwait[i], cnt_m[i]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dren[i] = 1'b0; dwen[i] = 1'b0; daddr[i] = '0; dstore[i] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (dwait[i] !== 1'b1 || dload[i] !== 32'h0 || xfer[i] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got dwait=%b dload=%h cnt=%h, want 1/0/0",
                         i, dwait[i], dload[i], xfer[i]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_read();
        do_xfer(0, 0, 0, 32'h0000_0040, 32'h0, "read40");
    endtask

    task automatic test_write_read();
        do_xfer(0, 1, 0, 32'h44, 32'hDEAD_BEEF, "wr44");
        do_xfer(0, 0, 0, 32'h44, 32'h0, "rd44");
        do_xfer(0, 0, 0, 32'h48, 32'h0, "rd48");
    endtask

    task automatic test_alias();
        do_xfer(0, 1, 0, 32'h0000_1004, 32'h1234_5678, "wr1004");
        do_xfer(0, 0, 0, 32'h0000_0004, 32'h0, "rd0004");
        do_xfer(0, 0, 0, 32'h0000_0046, 32'h0, "rd0046");
    endtask

    task automatic test_abort();
        int k;
        do_xfer(0, 1, 0, 32'h80, 32'h1111_1111, "abort_pre80");
        do_xfer(0, 1, 0, 32'h84, 32'hCAFE_F00D, "abort_pre84");
        dren[0]  = 1'b1;
        daddr[0] = 32'h80;
        @(posedge clk); #1;
        daddr[0] = 32'h84;
        k = 0;
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (dwait[0] === 1'b0) break;
        end
        n_chk++;
        if (k < lat(0) + 1 || k > lat(0) + 2) begin
            n_fail++;
            $display("FAIL abort latency: got %0d cycles after switch, want %0d..%0d",
                     k, lat(0) + 1, lat(0) + 2);
        end
        dload_m[0] = mem_m[0][33];
        n_chk++;
        if (dload[0] !== dload_m[0]) begin
            n_fail++;
            $display("FAIL abort dload: got %h, want %h", dload[0], dload_m[0]);
        end
        @(posedge clk); #1;
        dren[0] = 1'b0;
        cnt_m[0]++;
        n_chk++;
        if (xfer[0] !== cnt_m[0]) begin
            n_fail++;
            $display("FAIL abort count: got %h, want %h", xfer[0], cnt_m[0]);
        end
    endtask

    task automatic test_both();
        do_xfer(0, 1, 1, 32'h10, 32'hA5A5_A5A5, "both_wr10");
        do_xfer(0, 0, 0, 32'h10, 32'h0, "both_rd10");
    endtask

    task automatic test_back_to_back();
        int k;
        int last;
        logic [15:0] c0;
        for (int w = 0; w < 4; w++) begin
            do_xfer(1, 1, 0, 32'(w * 4), 32'hB000_0000 + 32'(w), "blk_pre");
        end
        c0 = cnt_m[1];
        last = 0;
        dren[1]  = 1'b1;
        daddr[1] = 32'h0;
        for (int w = 0; w < 4; w++) begin
            k = 0;
            while (k < 10) begin
                @(posedge clk); #1;
                k++;
                if (dwait[1] === 1'b0) break;
            end
            n_chk++;
            if ((w == 0 && k != 1) || (w > 0 && cyc - last != 2)) begin
                n_fail++;
                $display("FAIL blk_gap word %0d: got k=%0d gap=%0d, want k=1 / gap=2",
                         w, k, cyc - last);
            end
            last = cyc;
            dload_m[1] = mem_m[1][w];
            n_chk++;
            if (dload[1] !== dload_m[1]) begin
                n_fail++;
                $display("FAIL blk_data word %0d: got %h, want %h", w, dload[1], dload_m[1]);
            end
            @(posedge clk); #1;
            cnt_m[1]++;
            if (w < 3) daddr[1] = 32'((w + 1) * 4);
            else       dren[1]  = 1'b0;
        end
        n_chk++;
        if (xfer[1] !== c0 + 16'd4) begin
            n_fail++;
            $display("FAIL blk_count: got %h, want %h", xfer[1], c0 + 16'd4);
        end
    endtask

    task automatic test_random();
        int i;
        bit wr;
        bit both;
        logic [31:0] addr;
        for (int n = 0; n < 60; n++) begin
            i    = $urandom_range(0, 1);
            wr   = 1'($urandom_range(0, 1));
            both = wr & 1'($urandom_range(0, 1));
            addr = ($urandom & 32'hFFFF_F000)
                 | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            do_xfer(i, wr, both, addr, $urandom, "rand");
        end
    endtask

    task automatic test_reset_mid();
        dwen[0]   = 1'b1;
        daddr[0]  = 32'h20;
        dstore[0] = 32'h55AA_33CC;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (dwait[0] !== 1'b1 || xfer[0] !== 16'h0 || dload[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got dwait=%b cnt=%h dload=%h, want 1/0/0",
                     dwait[0], xfer[0], dload[0]);
        end
        dwen[0] = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_xfer(0, 0, 0, 32'h20, 32'h0, "rst_rd20");
    endtask

    task automatic test_wrap();
        force u1.xfer_count = 16'hFFFF;
        @(posedge clk); #1;
        release u1.xfer_count;
        cnt_m[1] = 16'hFFFF;
        @(posedge clk); #1;
        n_chk++;
        if (xfer[1] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preset: got %h, want ffff", xfer[1]);
        end
        do_xfer(1, 0, 0, 32'h8, 32'h0, "wrap");
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        test_reset();
        test_basic_read();
        test_write_read();
        test_alias();
        test_abort();
        test_both();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
